// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: UART receiver driven by a 16x (OVERSAMPLE) baud tick.
// Samples rx mid-bit, deserialises LSB-first frames and emits one-clock
// data_valid / frame_err / parity_err strobes.
// Optional parity bit: compile with `define UART_RX_PARITY_EN.
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // Elaboration-time parameter sanity checks
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_oversample: DATA_BITS must be in 5..9");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_oversample: OVERSAMPLE must be even and >= 8");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_oversample: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;

`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic                   parity_bit;
`endif

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: advances only on tick; strobes default low every clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            tick_cnt <= '0;
                            state    <= S_START;
                        end
                    end

                    S_START: begin
                        if (tick_cnt == TICK_MID) begin
                            if (!rx_s) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= S_DATA;
                            end else begin
                                // line went high again before mid start: glitch
                                state <= S_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt   <= '0;
                            parity_bit <= rx_s;
                            state      <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif

                    S_STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err <= (^shift_reg) ^ ODD ^ parity_bit;
`endif
                                state      <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_WAIT_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    S_WAIT_IDLE: begin
                        // hold off hunting until the line (break) returns high
                        if (rx_s) begin
                            state <= S_IDLE;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign busy = (state != S_IDLE);

endmodule
